// File: rtl/queue_drain.sv
// Drains a commanded burst from the queue FIFO onto a valid/ready stream via a skid buffer.
// Define QUEUE_DRAIN_REG_READY_EN for a 3-entry buffer whose pop rule has no m_ready path.
module queue_drain #(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic                 abort,
  input  logic                 q_empty,
  input  logic [DWIDTH-1:0]    q_dout,
  output logic                 q_deq,
  output logic                 m_valid,
  output logic [DWIDTH-1:0]    m_data,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] word_cnt
);

`ifdef QUEUE_DRAIN_REG_READY_EN
  localparam int unsigned DEPTH = 3;
`else
  localparam int unsigned DEPTH = 2;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DWIDTH-1:0]     skid [DEPTH];

  logic                  xfer_c;
  logic [2:0]            fill_c;
  logic [1:0]            wr_idx_c;

  // Stream side is a direct decode of the skid buffer registers; entry 0 is the oldest.
  assign m_valid = (occ != 2'd0);
  assign m_data  = skid[0];
  assign m_last  = m_valid && (word_cnt == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));
  assign xfer_c  = m_valid && m_ready;

  // Projected buffer fill if a pop were issued now.
`ifdef QUEUE_DRAIN_REG_READY_EN
  assign fill_c = 3'(occ) + 3'(inflight);
`else
  assign fill_c = 3'(occ) + 3'(inflight) - 3'(xfer_c);
`endif

  assign q_deq = (state == RUN) && !q_empty && !abort && (issued < len_q) &&
                 (fill_c < 3'(DEPTH));

  // Arriving word lands behind whatever survives this cycle's transfer.
  assign wr_idx_c = 2'(occ - 2'(xfer_c));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) skid[i] <= '0;
    end else begin
      inflight <= q_deq;
      occ      <= 2'(occ + 2'(inflight) - 2'(xfer_c));
      done     <= 1'b0;

      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (xfer_c) skid[i] <= skid[i+1];
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (inflight && (wr_idx_c == 2'(i))) skid[i] <= q_dout;
      end

      if (xfer_c && (word_cnt != '1)) word_cnt <= word_cnt + LEN_WIDTH'(1);

      case (state)
        IDLE: begin
          if (start && (burst_len != '0)) begin
            state    <= RUN;
            len_q    <= burst_len;
            issued   <= '0;
            word_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (q_deq) issued <= issued + LEN_WIDTH'(1);
          if (abort || (q_deq && ((issued + LEN_WIDTH'(1)) == len_q))) state <= FLUSH;
        end
        FLUSH: begin
          // Wait for the last popped word to land and leave the buffer.
          if (!inflight && (occ == 2'd0)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_drain.sv
// Directed bench for queue_drain: behavioural queue model, stream monitor, immediate-assert checks.
module tb_queue_drain;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] q_dout = '0;
  logic          q_empty;
  logic          q_deq, m_valid, m_last, busy, done;
  logic [DW-1:0] m_data;
  logic [LW-1:0] word_cnt;

  int errors = 0;
  int checks = 0;

  // Queue model: initial block owns writes (wr_n, flush_to), clocked block owns reads (rd_n).
  logic [DW-1:0] mem [256];
  int wr_n = 0, rd_n = 0, flush_to = 0, rp;
  assign rp      = (rd_n > flush_to) ? rd_n : flush_to;
  assign q_empty = (rp == wr_n);

  logic [DW-1:0] got [$];
  logic          lastv [$];
  int cyc = 0, deq_n = 0, deq_first = 0, deq_last = 0, xf_first = 0, xf_last = 0, done_n = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  queue_drain #(.DWIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .burst_len(burst_len), .abort(abort),
    .q_empty(q_empty), .q_dout(q_dout), .q_deq(q_deq), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (q_deq && !q_empty) begin
      q_dout <= mem[rp];
      rd_n   <= rp + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor samples just before each rising edge, once inputs have settled.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (rstn) begin
      if (q_deq) begin
        chk("pop_while_empty", 32'(q_empty), 32'd0);
        deq_n++;
        if (deq_n == 1) deq_first = cyc;
        deq_last = cyc;
      end
      if (hold_pend) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, hold_d);
        chk("hold_last", 32'(m_last), 32'(hold_l));
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lastv.push_back(m_last);
        if (got.size() == 1) xf_first = cyc;
        xf_last = cyc;
      end
      if (done) done_n++;
      hold_pend = m_valid && !m_ready;
      hold_d    = m_data;
      hold_l    = m_last;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic push(input logic [DW-1:0] d);
    mem[wr_n % 256] = d;
    wr_n++;
  endtask

  task automatic qflush();
    flush_to = wr_n;
  endtask

  task automatic clr();
    got.delete();
    lastv.delete();
    deq_n = 0; done_n = 0; deq_first = 0; deq_last = 0; xf_first = 0; xf_last = 0;
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    burst_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 1 drives m_ready with the repeating pattern 1,0,0.
  task automatic wait_done(input string tag, input int mode);
    int  k = 0;
    bit  ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mode == 1) m_ready = ((k % 3) == 0);
      k++;
      @(negedge clk);
      if (done_n > 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [DW-1:0] base, input int n,
                             input bit has_last);
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({tag, "_data"}, got[i], 32'(base + 32'(i)));
      chk({tag, "_last"}, 32'(lastv[i]), 32'(has_last && (i == n - 1)));
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_q_deq", 32'(q_deq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Full-rate burst of 5
    for (int i = 0; i < 5; i++) push(32'h10 + 32'(i));
    m_ready = 1'b1;
    clr();
    do_start(8'd5);
    wait_done("b5", 0);
    chk("b5_deq_n", 32'(deq_n), 32'd5);
    chk("b5_deq_span", 32'(deq_last - deq_first), 32'd4);
    chk("b5_first_latency", 32'(xf_first - deq_first), 32'd2);
    chk("b5_xfer_span", 32'(xf_last - xf_first), 32'd4);
    check_words("b5", 32'h10, 5, 1'b1);
    chk("b5_done_n", 32'(done_n), 32'd1);
    chk("b5_word_cnt", 32'(word_cnt), 32'd5);
    chk("b5_busy", 32'(busy), 32'd0);

    // Downstream stalls with ready pattern 1,0,0
    for (int i = 0; i < 4; i++) push(32'h20 + 32'(i));
    clr();
    do_start(8'd4);
    wait_done("stall", 1);
    check_words("stall", 32'h20, 4, 1'b1);
    chk("stall_done_n", 32'(done_n), 32'd1);
    chk("stall_word_cnt", 32'(word_cnt), 32'd4);

    // Queue runs dry mid-burst
    push(32'h30);
    push(32'h31);
    clr();
    do_start(8'd4);
    repeat (12) @(negedge clk);
    chk("dry_busy", 32'(busy), 32'd1);
    chk("dry_deq_n", 32'(deq_n), 32'd2);
    chk("dry_got", 32'(got.size()), 32'd2);
    chk("dry_done_n", 32'(done_n), 32'd0);
    push(32'h32);
    push(32'h33);
    wait_done("dry", 0);
    check_words("dry", 32'h30, 4, 1'b1);
    chk("dry_word_cnt", 32'(word_cnt), 32'd4);

    // Abort after the third pop
    for (int i = 0; i < 8; i++) push(32'h40 + 32'(i));
    clr();
    do_start(8'd8);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (deq_n >= 3) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("abort_wait3", 32'(seen), 32'd1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("abort", 0);
    chk("abort_deq_n", 32'(deq_n), 32'd3);
    check_words("abort", 32'h40, 3, 1'b0);
    chk("abort_done_n", 32'(done_n), 32'd1);
    chk("abort_word_cnt", 32'(word_cnt), 32'd3);
    qflush();

    // Zero-length start is ignored
    for (int i = 0; i < 3; i++) push(32'h50 + 32'(i));
    clr();
    do_start(8'd0);
    repeat (5) @(negedge clk);
    chk("zero_deq_n", 32'(deq_n), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_done_n", 32'(done_n), 32'd0);

    // Start while busy is ignored
    m_ready = 1'b0;
    clr();
    do_start(8'd3);
    repeat (3) @(negedge clk);
    chk("busy_busy", 32'(busy), 32'd1);
    do_start(8'd7);
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    wait_done("busy", 0);
    check_words("busy", 32'h50, 3, 1'b1);
    chk("busy_deq_n", 32'(deq_n), 32'd3);
    chk("busy_word_cnt", 32'(word_cnt), 32'd3);
    chk("busy_done_n", 32'(done_n), 32'd1);

    // Reset mid-burst with data held
    for (int i = 0; i < 4; i++) push(32'h60 + 32'(i));
    clr();
    do_start(8'd4);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (got.size() >= 1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rstmid_first", 32'(seen), 32'd1);
    end
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_valid_pre", 32'(m_valid), 32'd1);
    chk("rstmid_cnt_pre", 32'(word_cnt), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_valid", 32'(m_valid), 32'd0);
    chk("rstmid_q_deq", 32'(q_deq), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_word_cnt", 32'(word_cnt), 32'd0);
    chk("rstmid_last", 32'(m_last), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    qflush();
    push(32'h70);
    push(32'h71);
    m_ready = 1'b1;
    @(negedge clk);
    clr();
    do_start(8'd2);
    wait_done("post", 0);
    check_words("post", 32'h70, 2, 1'b1);
    chk("post_word_cnt", 32'(word_cnt), 32'd2);
    chk("post_done_n", 32'(done_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/queue_drain.md
Name: queue_drain

Overview:
- Consumer-side controller for the team's `queue` FIFO (enq/deq/din/dout/full/empty).
- Pops a commanded number of words from the queue and presents them on a valid/ready stream to downstream logic.
- Absorbs the queue's one-cycle registered dout latency with an internal skid buffer, so no word is lost or duplicated when downstream stalls.
- Sits between the queue's deq/dout/empty pins and the downstream consumer.

Parameters:
- DWIDTH, 32, data width; matches the queue's DWIDTH.
- LEN_WIDTH, 8, width of the burst length and word counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle command pulse; sampled only in IDLE.
- burst_len  input  LEN_WIDTH  number of words to drain; sampled with start.
- abort  input  1  stop issuing pops; finish the words already in flight.
- q_empty  input  1  queue empty flag.
- q_dout  input  DWIDTH  queue read data; valid the cycle after q_deq.
- q_deq  output  1  pop request to the queue.
- m_valid  output  1  downstream data valid.
- m_data  output  DWIDTH  downstream data.
- m_last  output  1  marks the final word of a complete (non-aborted) burst.
- m_ready  input  1  downstream accept.
- busy  output  1  high in RUN and FLUSH.
- done  output  1  one-cycle pulse at the end of a burst.
- word_cnt  output  LEN_WIDTH  words accepted downstream in the current or last burst.

Behaviour:
- Reset (async): state=IDLE; q_deq=0; m_valid=0; m_last=0; m_data=0; busy=0; done=0; word_cnt=0; buffer emptied; in-flight flag=0; issue count=0.
- The in-flight flag (inflight) is q_deq registered; it means q_dout carries a new word this cycle. The word is written into the skid buffer on that edge.
- Skid buffer:
  - 2-entry FIFO; occ is its occupancy, 0..2.
  - m_valid = (occ != 0); m_data = the oldest entry.
  - A transfer happens on m_valid && m_ready.
  - Holding rule: m_data and m_last hold stable while m_valid=1 && m_ready=0.
- Pop rule in RUN: q_deq = !q_empty && !abort && (issued < burst_len) && (occ + inflight - (m_valid && m_ready) < 2). This is a combinational path from m_ready to q_deq.
- Throughput: 1 word/cycle sustained when q_empty=0 and m_ready=1. First m_valid appears 2 cycles after the first q_deq.
- State machine:
  - IDLE: start && burst_len != 0 -> RUN; latch burst_len; clear issued and word_cnt. start with burst_len=0 is ignored (no done pulse).
  - RUN: issued increments on each q_deq. Go to FLUSH when issued reaches burst_len, or on abort. abort has priority: no q_deq in the same cycle.
  - FLUSH: q_deq=0. Go to DONE when inflight=0 && occ=0 && no transfer pending.
  - DONE: done=1 for exactly one cycle -> IDLE. busy=0 in DONE.
- word_cnt increments on each transfer and saturates at all-ones. It holds its value after DONE until the next accepted start.
- m_last = 1 on the word whose transfer makes word_cnt == latched burst_len. It is never asserted for an aborted burst shorter than burst_len.
- q_empty=1 mid-burst: RUN waits indefinitely with no pops; busy stays 1. Draining resumes when q_empty falls.
- start while busy: ignored.
- Simultaneous buffer write (inflight) and transfer in the same cycle: occ unchanged; ordering preserved.
- Reset mid-burst: all state cleared immediately. Words held in the skid buffer are discarded; words already popped from the queue are lost (documented behaviour).

Optional Feature:
- Macro QUEUE_DRAIN_REG_READY_EN.
- When defined:
  - Skid buffer is 3 entries.
  - Pop rule becomes occ + inflight < 3, with no m_ready term, removing the m_ready->q_deq combinational path.
  - Sustained throughput stays at 1 word/cycle.
- When undefined: 2-entry buffer with the ready-qualified pop rule above.
- All other behaviour, latencies to first m_valid, and reset values are identical in both builds.

Test Plan:
- Queue preloaded with 0x10..0x14, start with burst_len=5, m_ready=1 -> q_deq high 5 consecutive cycles; m_data 0x10..0x14 on consecutive cycles; m_last only with 0x14; done pulses once; word_cnt=5.
- burst_len=4, m_ready toggling 1,0,0,1,... -> each word delivered exactly once, in order, with m_data stable during stalls; buffer never exceeds capacity; done pulses after the 4th transfer.
- Queue holds 2 words, burst_len=4, 3rd and 4th words enqueued 10 cycles later -> busy stays 1 with no q_deq while q_empty=1; all 4 words delivered; m_last on the 4th.
- burst_len=8, abort asserted after the 3rd q_deq -> no further q_deq; all 3 popped words delivered; m_last never asserted; done pulses; word_cnt=3.
- start with burst_len=0 -> no q_deq, busy stays 0, no done. Also: start pulsed while busy -> ignored.
- rstn low for 1 cycle mid-burst with m_valid=1 -> m_valid, q_deq, busy drop immediately; word_cnt=0; after release a new start drains correctly.
